// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern scanner.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int PAT_W   = 4;
   localparam int WORD_W  = 8;
   localparam int CNT_MAX = 255;
   localparam int FILL_W  = 3;

   localparam logic [PAT_W-1:0]  PAT_RST  = 4'b1011;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'(CNT_MAX)) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/seq_window.sv
// Bit history window: fill tracking and pattern compare on the bit being shifted in.
module seq_window
   import seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             shift,
   input  logic             clear,
   input  logic             overlap,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);

   logic [PAT_W-1:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  w_hist_nxt;
   logic [FILL_W-1:0] w_fill_nxt;

   always_comb begin
      w_hist_nxt = {r_hist[PAT_W-2:0], bit_in};
      w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
      match      = shift && (w_hist_nxt == pattern) && (w_fill_nxt == FILL_MAX);
   end

   // Non-overlapping mode restarts the fill so the next match needs four fresh bits
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (shift) begin
         r_hist <= w_hist_nxt;
         r_fill <= (match && !overlap) ? '0 : w_fill_nxt;
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame-based serial pattern scanner: accepts words, shifts them MSB first
// through a 4-bit window, pulses hit per match and reports a per-frame count.
module seq_scan_ctrl
   import seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              cfg_overlap,
   output logic              cfg_busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              hit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_count
);

   state_t            r_state, w_state_nxt;
   logic [WORD_W-1:0] r_sreg;
   logic [2:0]        r_bitcnt;
   logic              r_last;
   logic              r_in_frame;
   logic [PAT_W-1:0]  r_pattern;
   logic              r_overlap;
   logic              r_hit;
   logic [7:0]        r_count;

   logic w_accept, w_done, w_shift, w_clear, w_match;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      cfg_busy    = !((r_state == IDLE) && !r_in_frame);
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            if (r_bitcnt == 3'd7) w_state_nxt = r_last ? REPORT : IDLE;
         end
         REPORT: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_accept  = in_valid && in_ready;
   assign w_done    = out_valid && out_ready;
   assign w_shift   = (r_state == SHIFT);
   assign w_clear   = (w_accept && !r_in_frame) || w_done;
   assign hit       = r_hit;
   assign out_count = r_count;

   seq_window u_window (
      .clk     (clk),
      .rst     (rst),
      .bit_in  (r_sreg[WORD_W-1]),
      .shift   (w_shift),
      .clear   (w_clear),
      .overlap (r_overlap),
      .pattern (r_pattern),
      .match   (w_match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_sreg     <= '0;
         r_bitcnt   <= '0;
         r_last     <= 1'b0;
         r_in_frame <= 1'b0;
         r_pattern  <= PAT_RST;
         r_overlap  <= 1'b1;
         r_hit      <= 1'b0;
         r_count    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hit   <= w_match;
         if (cfg_we && !cfg_busy) begin
            r_pattern <= cfg_pattern;
            r_overlap <= cfg_overlap;
         end
         if (w_accept) begin
            r_sreg     <= in_data;
            r_bitcnt   <= '0;
            r_last     <= in_last;
            r_in_frame <= 1'b1;
         end else if (w_shift) begin
            r_sreg   <= {r_sreg[WORD_W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         // Handshake and match never coincide: matches only occur in SHIFT
         if (w_done) begin
            r_count    <= '0;
            r_in_frame <= 1'b0;
         end else if (w_match) begin
            r_count <= sat_inc8(r_count);
         end
      end
   end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: a behavioural window model predicts per-bit hits and frame counts.
module tb_seq_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst, cfg_we, cfg_overlap, cfg_busy;
   logic [3:0] cfg_pattern;
   logic       in_valid, in_ready, in_last, hit, out_valid, out_ready;
   logic [7:0] in_data, out_count;

   int checks = 0;
   int failures = 0;

   bit exp_hit_q[$];
   int exp_cnt_q[$];

   logic [3:0] m_pat;
   bit         m_ovl;
   logic [3:0] m_hist;
   int         m_fill, m_cnt;
   bit         m_inframe;

   seq_scan_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .cfg_busy    (cfg_busy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .hit         (hit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_count   (out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m_pat = 4'b1011;
      m_ovl = 1'b1;
      m_hist = '0;
      m_fill = 0;
      m_cnt = 0;
      m_inframe = 1'b0;
      exp_hit_q.delete();
      exp_cnt_q.delete();
   endtask

   // Accept one word, predict its 8 hit slots, then compare hit after each shift edge.
   task automatic send_word(input logic [7:0] d, input bit last, input bit poke_cfg);
      int n;
      bit m;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_wait in_ready=%b expected=1", in_ready);
      end
      if (!m_inframe) begin
         m_hist = '0;
         m_fill = 0;
      end
      m_inframe = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         m_hist = {m_hist[2:0], d[i]};
         if (m_fill < 4) m_fill++;
         m = (m_fill == 4) && (m_hist == m_pat);
         exp_hit_q.push_back(m);
         if (m) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) m_fill = 0;
         end
      end
      if (last) exp_cnt_q.push_back(m_cnt);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      if (poke_cfg) begin
         cfg_we      = 1'b1;
         cfg_pattern = 4'b0000;
         cfg_overlap = 1'b0;
      end
      for (int b = 0; b < 8; b++) begin
         bit e;
         step();
         e = exp_hit_q.pop_front();
         checks++;
         if (hit !== e) begin
            failures++;
            $display("FAIL hit_bit%0d word=%b got=%b expected=%b", b, d, hit, e);
         end
      end
      cfg_we = 1'b0;
   endtask

   task automatic collect_report(input int hold);
      int n, e;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL report_wait out_valid=%b expected=1", out_valid);
      end
      e = (exp_cnt_q.size() > 0) ? exp_cnt_q.pop_front() : -1;
      checks++;
      if (out_count !== 8'(e)) begin
         failures++;
         $display("FAIL report_count got=%0d expected=%0d", out_count, e);
      end
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_count !== 8'(e) || in_ready !== 1'b0 || cfg_busy !== 1'b1) begin
            failures++;
            $display("FAIL report_hold cyc=%0d valid=%b count=%0d in_ready=%b busy=%b expected 1/%0d/0/1",
                     i, out_valid, out_count, in_ready, cfg_busy, e);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd0 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL report_done valid=%b in_ready=%b count=%0d busy=%b expected 0/1/0/0",
                  out_valid, in_ready, out_count, cfg_busy);
      end
      m_cnt = 0;
      m_inframe = 1'b0;
      m_hist = '0;
      m_fill = 0;
   endtask

   task automatic cfg_write(input logic [3:0] p, input bit o);
      int n;
      n = 0;
      while (cfg_busy && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL cfg_wait busy=%b expected=0", cfg_busy);
      end
      cfg_we = 1'b1;
      cfg_pattern = p;
      cfg_overlap = o;
      step();
      cfg_we = 1'b0;
      m_pat = p;
      m_ovl = o;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step();
      step();
      checks++;
      if (hit !== 1'b0 || out_valid !== 1'b0 || out_count !== 8'd0 || in_ready !== 1'b1 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs hit=%b valid=%b count=%0d in_ready=%b busy=%b expected 0/0/0/1/0",
                  hit, out_valid, out_count, in_ready, cfg_busy);
      end
      rst = 1'b0;
      model_reset();
      step();
      checks++;
      if (in_ready !== 1'b1 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release in_ready=%b busy=%b expected 1/0", in_ready, cfg_busy);
      end
   endtask

   task automatic test_overlap;
      send_word(8'b10110110, 1'b1, 1'b0);
      collect_report(0);
   endtask

   task automatic test_no_overlap;
      cfg_write(4'b1011, 1'b0);
      send_word(8'b10110110, 1'b1, 1'b0);
      collect_report(0);
      cfg_write(4'b1011, 1'b1);
   endtask

   task automatic test_cross_word;
      send_word(8'b00000101, 1'b0, 1'b0);
      checks++;
      if (cfg_busy !== 1'b1 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_frame busy=%b in_ready=%b expected 1/1", cfg_busy, in_ready);
      end
      send_word(8'b10000000, 1'b1, 1'b0);
      collect_report(0);
      send_word(8'b00000101, 1'b1, 1'b0);
      collect_report(0);
      send_word(8'b10000000, 1'b1, 1'b0);
      collect_report(0);
   endtask

   task automatic test_back_to_back;
      send_word(8'b10110110, 1'b1, 1'b0);
      collect_report(5);
      for (int i = 0; i < 200; i++) send_word(8'hBB, i == 199, 1'b0);
      collect_report(2);
   endtask

   task automatic test_reset_mid_word;
      in_valid = 1'b1;
      in_data = 8'b10110110;
      in_last = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      checks++;
      if (hit !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_word hit=%b in_ready=%b valid=%b count=%0d busy=%b expected 0/1/0/0/0",
                  hit, in_ready, out_valid, out_count, cfg_busy);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (hit !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_quiet cyc=%0d hit=%b valid=%b expected 0/0", i, hit, out_valid);
         end
      end
   endtask

   task automatic test_cfg_during_shift;
      send_word(8'b00000000, 1'b1, 1'b1);
      collect_report(0);
      send_word(8'b10110110, 1'b1, 1'b0);
      collect_report(0);
   endtask

   initial begin
      rst = 1'b1;
      cfg_we = 1'b0;
      cfg_pattern = '0;
      cfg_overlap = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      out_ready = 1'b0;
      model_reset();
      test_reset();
      test_overlap();
      test_no_overlap();
      test_cross_word();
      test_back_to_back();
      test_reset_mid_word();
      test_cfg_during_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
